// File: rtl/split_data.sv
// Splits a 2*WIDTH-bit sample into bytes, MSB first, for the UART TX core; SPLIT_SYNC_EN prepends SYNC_BYTE.
// First tx_start_o 2 clk after an accepted start_i; stalls on tx_busy_i, start_i ignored while ready_o=0.
module split_data #(
  parameter int          WIDTH     = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic signed [2*WIDTH-1:0] data_i,
  output logic                      ready_o,
  input  logic                      tx_busy_i,
  output logic                      tx_start_o,
  output logic signed [7:0]         data_uart_o,
  output logic                      split_finished_o
);

  localparam int SW     = 2 * WIDTH;
  localparam int NBYTES = SW / 8;
`ifdef SPLIT_SYNC_EN
  localparam int CW     = $clog2(NBYTES + 2);
  localparam int NLOAD  = NBYTES + 1;
`else
  localparam int CW     = $clog2(NBYTES + 1);
  localparam int NLOAD  = NBYTES;
`endif
  localparam logic [CW-1:0] CNT_LOAD = CW'(NLOAD);

  if ((SW % 8) != 0 || $bits(SYNC_BYTE) != 8) begin : g_bad_cfg
    $error("split_data: 2*WIDTH must be a multiple of 8");
  end

  typedef enum logic [1:0] {IDLE, SEND, ACK, DONE} state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     sh, sh_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              ready_nxt, tx_start_nxt, fin_nxt;
  logic signed [7:0] data_uart_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      sh               <= '0;
      cnt              <= '0;
      ready_o          <= 1'b1;
      tx_start_o       <= 1'b0;
      data_uart_o      <= '0;
      split_finished_o <= 1'b0;
    end else begin
      state            <= state_nxt;
      sh               <= sh_nxt;
      cnt              <= cnt_nxt;
      ready_o          <= ready_nxt;
      tx_start_o       <= tx_start_nxt;
      data_uart_o      <= data_uart_nxt;
      split_finished_o <= fin_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sh_nxt        = sh;
    cnt_nxt       = cnt;
    ready_nxt     = ready_o;
    tx_start_nxt  = 1'b0;
    data_uart_nxt = data_uart_o;
    fin_nxt       = 1'b0;
    case (state)
      IDLE: begin
        // The completion-pulse cycle is already IDLE but must not accept a new load.
        if (start_i && !split_finished_o) begin
          sh_nxt    = data_i;
          cnt_nxt   = CNT_LOAD;
          ready_nxt = 1'b0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (!tx_busy_i) begin
          tx_start_nxt = 1'b1;
          cnt_nxt      = cnt - CW'(1);
          state_nxt    = ACK;
`ifdef SPLIT_SYNC_EN
          if (cnt == CNT_LOAD) begin
            data_uart_nxt = SYNC_BYTE;
          end else begin
            data_uart_nxt = sh[SW-1 -: 8];
            sh_nxt        = sh << 8;
          end
`else
          data_uart_nxt = sh[SW-1 -: 8];
          sh_nxt        = sh << 8;
`endif
        end
      end
      ACK: begin
        if (tx_busy_i) state_nxt = DONE;
      end
      DONE: begin
        if (!tx_busy_i) begin
          if (cnt != '0) begin
            state_nxt = SEND;
          end else begin
            fin_nxt   = 1'b1;
            ready_nxt = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_split_data.sv
// Scoreboard bench for split_data: UART busy model plus byte-merge model on the receive side.
module tb_split_data;

  logic               clk = 1'b0;
  logic               rst;
  logic               start_i;
  logic signed [31:0] data_i;
  logic               ready_o;
  logic               tx_busy_i;
  logic               tx_start_o;
  logic signed [7:0]  data_uart_o;
  logic               split_finished_o;

  always #5 clk = ~clk;

  split_data #(.WIDTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .data_i           (data_i),
    .ready_o          (ready_o),
    .tx_busy_i        (tx_busy_i),
    .tx_start_o       (tx_start_o),
    .data_uart_o      (data_uart_o),
    .split_finished_o (split_finished_o)
  );

`ifdef SPLIT_SYNC_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] word_q[$];
  logic [31:0] acc = '0;
  int          fin_cnt = 0;
  int          tx_cnt = 0;
  int          uart_left = 0;
  int          uart_len = 10;
  logic        uart_busy = 1'b0;
  logic        ext_busy = 1'b0;

  assign tx_busy_i = uart_busy | ext_busy;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // UART busy model, byte scoreboard and receive-side merge, all sampled on the falling edge.
  always @(negedge clk) begin
    if (uart_left > 0) begin
      uart_left--;
      if (uart_left == 0) uart_busy = 1'b0;
    end
    if (!rst) begin
      acc = '0;
      exp_q.delete();
      word_q.delete();
    end
    if (tx_start_o) begin
      tx_cnt++;
      uart_busy = 1'b1;
      uart_left = uart_len;
      if (exp_q.size() == 0) check("extra_byte", 32'(exp_q.size()), 32'd1);
      else check("byte", {24'h0, data_uart_o}, {24'h0, exp_q.pop_front()});
      acc = {acc[23:0], data_uart_o};
    end
    if (split_finished_o) begin
      fin_cnt++;
      check("ready_at_fin", {31'h0, ready_o}, 32'd1);
      check("bytes_left_at_fin", 32'(exp_q.size()), 32'd0);
      if (word_q.size() == 0) check("extra_fin", 32'(word_q.size()), 32'd1);
      else check("merged", acc, word_q.pop_front());
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!(ready_o && !split_finished_o) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'h0, ready_o && !split_finished_o}, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    wait_ready();
`ifdef SPLIT_SYNC_EN
    exp_q.push_back(8'hA5);
`endif
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
    word_q.push_back(w);
    start_i = 1'b1;
    data_i  = w;
    @(negedge clk);
    start_i = 1'b0;
    data_i  = $urandom;
  endtask

  task automatic wait_fin(input int target);
    int n = 0;
    while (fin_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("fin_wait", fin_cnt, target);
  endtask

  task automatic wait_tx(input int target);
    int n = 0;
    while (tx_cnt < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("tx_wait", tx_cnt, target);
  endtask

  initial begin
    int base;
    int fins;
    logic [31:0] w;
    rst     = 1'b0;
    start_i = 1'b0;
    data_i  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, ready_o}, 32'd1);
    check("rst_tx_start", {31'h0, tx_start_o}, 32'd0);
    check("rst_data_uart", {24'h0, data_uart_o}, 32'd0);
    check("rst_finished", {31'h0, split_finished_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic load with latency check, plus a start_i during the transfer that must be dropped.
    send_word(32'h1234ABCD);
    check("lat_cycle1", {31'h0, tx_start_o}, 32'd0);
    @(negedge clk);
    check("lat_cycle2", {31'h0, tx_start_o}, 32'd1);
    wait_tx(2);
    start_i = 1'b1;
    data_i  = 32'hDEADBEEF;
    @(negedge clk);
    start_i = 1'b0;
    wait_fin(1);
    check("ignored_start_bytes", tx_cnt, NB);
    send_word(32'hDEADBEEF);
    wait_fin(2);

    // UART held busy by another user before the load.
    ext_busy = 1'b1;
    repeat (20) @(negedge clk);
    base = tx_cnt;
    send_word(32'h12345678);
    repeat (10) @(negedge clk);
    check("prebusy_hold", tx_cnt, base);
    ext_busy = 1'b0;
    wait_fin(3);

    // Asynchronous reset after the second byte of a transfer.
    base = tx_cnt;
    send_word(32'h80000001);
    wait_tx(base + 2);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ready", {31'h0, ready_o}, 32'd1);
    check("mid_rst_tx_start", {31'h0, tx_start_o}, 32'd0);
    check("mid_rst_data_uart", {24'h0, data_uart_o}, 32'd0);
    check("mid_rst_finished", {31'h0, split_finished_o}, 32'd0);
    fins = fin_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("no_fin_after_rst", fin_cnt, fins);
    send_word(32'h00000080);
    wait_fin(fins + 1);

    send_word(32'h0102F0FF);
    wait_fin(fins + 2);

    // Loopback with a faster UART.
    uart_len = 3;
    fins = fin_cnt;
    for (int i = 0; i < 1000; i++) begin
      if (i == 0) w = 32'h80000000;
      else if (i == 1) w = 32'hFFFFFFFF;
      else w = $urandom;
      send_word(w);
    end
    wait_fin(fins + 1000);
    repeat (5) @(negedge clk);
    check("final_bytes_pending", 32'(exp_q.size()), 32'd0);
    check("final_words_pending", 32'(word_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
